power_domain_sequencer: RTL and testbench



---
 rtl/power_seq_pkg.sv | 54 +++++
 rtl/power_domain_sequencer_if.sv | 27 ++
 rtl/power_logic_ack_sync.sv | 23 ++
 rtl/power_domain_sequencer.sv | 139 +++++++++++++
 tb/tb_power_domain_sequencer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/power_seq_pkg.sv
// Shared types and per-state output decode for the power domain sequencer.
`timescale 1ns/1ps
package power_seq_pkg;

  typedef enum logic [3:0] {
    OFF,
    PWR_UP,
    RESTORE,
    RST_REL,
    ON,
    ISO,
    SAVE,
    RST_ASRT,
    PWR_DN
  } pwr_seq_state_t;

  // Control outputs driven into the switchable domain.
  typedef struct packed {
    logic switch_en;
    logic iso_en;
    logic domain_rst;
    logic ret_save;
    logic ret_restore;
  } seq_out_t;

  //                                       sw    iso   rst   save  rest
  localparam seq_out_t OUT_OFF      = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam seq_out_t OUT_PWR_UP   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam seq_out_t OUT_RESTORE  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam seq_out_t OUT_RST_REL  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam seq_out_t OUT_ON       = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam seq_out_t OUT_ISO      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam seq_out_t OUT_SAVE     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam seq_out_t OUT_RST_ASRT = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam seq_out_t OUT_PWR_DN   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic seq_out_t decode_outputs(pwr_seq_state_t s);
    seq_out_t o;
    case (s)
      OFF:      o = OUT_OFF;
      PWR_UP:   o = OUT_PWR_UP;
      RESTORE:  o = OUT_RESTORE;
      RST_REL:  o = OUT_RST_REL;
      ON:       o = OUT_ON;
      ISO:      o = OUT_ISO;
      SAVE:     o = OUT_SAVE;
      RST_ASRT: o = OUT_RST_ASRT;
      PWR_DN:   o = OUT_PWR_DN;
      default:  o = OUT_OFF;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/power_domain_sequencer_if.sv
// Request/acknowledge and domain-control signals of the power domain sequencer.
`timescale 1ns/1ps
interface power_domain_sequencer_if;
  logic pwr_on_req;
  logic fault_clr;
  logic switch_ack;
  logic switch_en;
  logic iso_en;
  logic ret_save;
  logic ret_restore;
  logic domain_rst;
  logic pwr_on_ack;
  logic busy;
  logic fault;

  modport master (
    output pwr_on_req, fault_clr, switch_ack,
    input  switch_en, iso_en, ret_save, ret_restore, domain_rst,
           pwr_on_ack, busy, fault
  );

  modport slave (
    input  pwr_on_req, fault_clr, switch_ack,
    output switch_en, iso_en, ret_save, ret_restore, domain_rst,
           pwr_on_ack, busy, fault
  );
endinterface

// File: rtl/power_logic_ack_sync.sv
// Two-flop synchronizer for the asynchronous switch-chain acknowledge.
`timescale 1ns/1ps
module power_logic_ack_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Shift the async level through two flops; both clear on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/power_domain_sequencer.sv
// Power-up / power-down sequencer for one switchable domain, in the always-on domain.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// OFF      | switch off, isolated, in reset; waits for request (no fault)
// PWR_UP   | switch enabled, waiting for synchronized ack (timeout -> fault)
// RESTORE  | retention restore strobe, only if state was saved before
// RST_REL  | domain reset released while still isolated
// ON       | domain running, isolation off, pwr_on_ack high
// ISO      | isolation re-applied, one cycle
// SAVE     | retention save strobe; marks state as saved on exit
// RST_ASRT | domain reset re-asserted, one cycle
// PWR_DN   | switch disabled, waiting for ack to drop (timeout -> fault)
`timescale 1ns/1ps
module power_domain_sequencer
  import power_seq_pkg::*;
#(
  parameter int SAVE_CYCLES    = 2,
  parameter int RESTORE_CYCLES = 2,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clock,
  input logic reset,
  power_domain_sequencer_if.slave bus
);

  localparam int MAX_A    = (SAVE_CYCLES > RESTORE_CYCLES) ? SAVE_CYCLES : RESTORE_CYCLES;
  localparam int MAX_B    = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] SAVE_LAST = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  pwr_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             saved_q, set_saved;
  logic             fault_q, set_fault, clr_fault;
  logic             ack_s;
  seq_out_t         out_q;
  logic             pwr_on_ack_q, busy_q;

  power_logic_ack_sync u_ack_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.switch_ack),
    .sync_out (ack_s)
  );

  // Next-state, fault/saved events and counter update.
  always_comb begin
    state_d   = state_q;
    set_saved = 1'b0;
    set_fault = 1'b0;
    clr_fault = 1'b0;
    case (state_q)
      OFF: begin
        clr_fault = bus.fault_clr;
        // Uses the registered fault so a coincident clear only takes effect next cycle.
        if (bus.pwr_on_req && !fault_q) state_d = PWR_UP;
      end
      PWR_UP: begin
        if (ack_s) begin
          state_d = saved_q ? RESTORE : RST_REL;
        end else if (count_q == TO_LAST) begin
          set_fault = 1'b1;
          state_d   = OFF;
        end
      end
      RESTORE:  if (count_q == REST_LAST) state_d = RST_REL;
      RST_REL:  if (count_q == RST_LAST) state_d = ON;
      ON:       if (!bus.pwr_on_req) state_d = ISO;
      ISO:      state_d = SAVE;
      SAVE: begin
        if (count_q == SAVE_LAST) begin
          set_saved = 1'b1;
          state_d   = RST_ASRT;
        end
      end
      RST_ASRT: state_d = PWR_DN;
      PWR_DN: begin
        if (!ack_s) begin
          state_d = OFF;
        end else if (count_q == TO_LAST) begin
          set_fault = 1'b1;
          state_d   = OFF;
        end
      end
      default:  state_d = OFF;
    endcase

    // Clear on every state entry, otherwise count up and stick at all-ones.
    if (state_d != state_q)  count_d = '0;
    else if (count_q != '1)  count_d = count_q + 1'b1;
    else                     count_d = count_q;
  end

  // State, counter and sticky flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      count_q <= '0;
      saved_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (set_saved) saved_q <= 1'b1;
      if (set_fault)      fault_q <= 1'b1;
      else if (clr_fault) fault_q <= 1'b0;
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q        <= OUT_OFF;
      pwr_on_ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      out_q        <= decode_outputs(state_d);
      pwr_on_ack_q <= (state_d == ON);
      busy_q       <= !((state_d == OFF) || (state_d == ON));
    end
  end

  assign bus.switch_en   = out_q.switch_en;
  assign bus.iso_en      = out_q.iso_en;
  assign bus.domain_rst  = out_q.domain_rst;
  assign bus.ret_save    = out_q.ret_save;
  assign bus.ret_restore = out_q.ret_restore;
  assign bus.pwr_on_ack  = pwr_on_ack_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Scoreboard bench for power_domain_sequencer: stimulus queues per-cycle expected
// output vectors, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_power_domain_sequencer;

  // Output vector: {switch_en, iso_en, domain_rst, ret_save, ret_restore, pwr_on_ack, busy, fault}
  localparam logic [7:0] V_OFF   = 8'h60;
  localparam logic [7:0] V_OFF_F = 8'h61;
  localparam logic [7:0] V_UP    = 8'hE2;
  localparam logic [7:0] V_REST  = 8'hEA;
  localparam logic [7:0] V_REL   = 8'hC2;
  localparam logic [7:0] V_ON    = 8'h84;
  localparam logic [7:0] V_ISO   = 8'hC2;
  localparam logic [7:0] V_SAVE  = 8'hD2;
  localparam logic [7:0] V_RASRT = 8'hE2;
  localparam logic [7:0] V_DN    = 8'h62;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ack_tie = 1'b1;
  logic ack_force = 1'b0;

  power_domain_sequencer_if bus ();

  assign bus.switch_ack = ack_tie ? bus.switch_en : ack_force;

  power_domain_sequencer #(
    .SAVE_CYCLES    (2),
    .RESTORE_CYCLES (2),
    .RST_CYCLES     (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  v;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] observed();
    return {bus.switch_en, bus.iso_en, bus.domain_rst, bus.ret_save,
            bus.ret_restore, bus.pwr_on_ack, bus.busy, bus.fault};
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if (e.cyc != cyc)
          $display("FAIL %s stale: due cycle %0d, checked at cycle %0d", e.name, e.cyc, cyc);
        else if (observed() === e.v)
          n_pass++;
        else
          $display("FAIL %s cycle %0d: got %h expected %h", e.name, cyc, observed(), e.v);
      end
    end
  end

  task automatic push_exp(int unsigned c, logic [7:0] v, string nm);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic step(logic req, logic clr, logic [7:0] v, string nm);
    bus.pwr_on_req = req;
    bus.fault_clr  = clr;
    push_exp(cyc + 1, v, nm);
    @(posedge clock);
    #2;
  endtask

  // Power-up from OFF with switch_ack following switch_en; optionally drop req
  // from the third edge on.
  task automatic up_seq(bit restore, bit drop_req, string nm);
    logic r;
    r = drop_req ? 1'b0 : 1'b1;
    step(1'b1, 1'b0, V_UP, {nm, "_up"});
    step(1'b1, 1'b0, V_UP, {nm, "_up"});
    step(r,    1'b0, V_UP, {nm, "_up"});
    if (restore) begin
      repeat (2) step(r, 1'b0, V_REST, {nm, "_restore"});
    end
    repeat (4) step(r, 1'b0, V_REL, {nm, "_rst_rel"});
    step(r, 1'b0, V_ON, {nm, "_on"});
  endtask

  task automatic down_seq(string nm);
    step(1'b0, 1'b0, V_ISO, {nm, "_iso"});
    repeat (2) step(1'b0, 1'b0, V_SAVE, {nm, "_save"});
    step(1'b0, 1'b0, V_RASRT, {nm, "_rst_asrt"});
    repeat (3) step(1'b0, 1'b0, V_DN, {nm, "_pwr_dn"});
    step(1'b0, 1'b0, V_OFF, {nm, "_off"});
  endtask

  initial begin
    bus.pwr_on_req = 1'b0;
    bus.fault_clr  = 1'b0;
    reset          = 1'b1;
    @(posedge clock);
    #2;
    push_exp(cyc, V_OFF, "reset_values");
    @(posedge clock);
    #2;
    reset = 1'b0;
    step(1'b0, 1'b0, V_OFF, "idle");

    // Cold power-up: no restore, ON after 8 edges.
    up_seq(1'b0, 1'b0, "cold");
    repeat (2) step(1'b1, 1'b0, V_ON, "hold_on");
    down_seq("down1");
    repeat (2) step(1'b0, 1'b0, V_OFF, "idle_off");

    // Warm power-up after a save: restore pulse.
    up_seq(1'b1, 1'b0, "warm");
    down_seq("down2");

    // Stuck ack: timeout after 64 cycles in PWR_UP, fault blocks requests.
    ack_tie   = 1'b0;
    ack_force = 1'b0;
    repeat (64) step(1'b1, 1'b0, V_UP, "wait_ack");
    step(1'b1, 1'b0, V_OFF_F, "timeout");
    repeat (3) step(1'b1, 1'b0, V_OFF_F, "fault_hold");
    step(1'b1, 1'b1, V_OFF, "fault_clr");
    ack_tie = 1'b1;
    up_seq(1'b1, 1'b0, "retry");
    down_seq("down3");

    // Request dropped during PWR_UP: completes to ON for one cycle, then reverses.
    up_seq(1'b1, 1'b1, "toggle");
    down_seq("toggle_dn");

    // Async reset in the middle of SAVE.
    up_seq(1'b1, 1'b0, "pre_rst");
    step(1'b0, 1'b0, V_ISO, "pre_rst_iso");
    step(1'b0, 1'b0, V_SAVE, "pre_rst_save");
    @(posedge clock);
    #2;
    reset = 1'b1;
    push_exp(cyc, V_OFF, "async_reset");
    step(1'b0, 1'b0, V_OFF, "reset_hold");
    reset = 1'b0;
    step(1'b0, 1'b0, V_OFF, "after_reset");
    up_seq(1'b0, 1'b0, "post_rst");
    down_seq("down4");

    repeat (3) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
